// File: rtl/volt_autorange_ctrl.sv
// Auto-ranging controller: tracks the peak-to-peak span of ADC samples over a
// window and steps the scaler gain index, with manual override and settle blanking.
module volt_autorange_ctrl #(
   parameter int WIN_LEN    = 1024,
   parameter int HI_TH      = 3000,
   parameter int LO_TH      = 300,
   parameter int SETTLE_CYC = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [11:0] SAMPLE_IN,
   input  logic        SAMPLE_VALID,
   input  logic        AUTO_EN,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   output logic [2:0]  SCALE,
   output logic        SCALE_CHANGED,
   output logic        BLANK,
   output logic [11:0] SPAN_OUT,
   output logic [1:0]  STATE_OUT
);

   localparam logic [1:0]  ACQ    = 2'd0;
   localparam logic [1:0]  DECIDE = 2'd1;
   localparam logic [1:0]  SETTLE = 2'd2;

   localparam logic [16:0] WIN_LAST    = 17'(WIN_LEN - 1);
   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYC);
   localparam logic [11:0] HI_LIM      = 12'(HI_TH);
   localparam logic [11:0] LO_LIM      = 12'(LO_TH);
   localparam logic [2:0]  SCALE_MAX   = 3'd4;

   logic [1:0]  state;
   logic [2:0]  scale;
   logic        scale_changed;
   logic [11:0] span_reg;
   logic [11:0] min_val;
   logic [11:0] max_val;
   logic [16:0] count;
   logic [7:0]  settle_cnt;

   logic [11:0] span;
   logic [11:0] next_min;
   logic [11:0] next_max;
   logic [2:0]  auto_scale;
   logic [2:0]  manual_scale;
   logic        auto_hit;
   logic        manual_hit;

   // max never falls below min once a window holds a sample, so this cannot wrap
   assign span     = max_val - min_val;
   assign next_min = (SAMPLE_IN < min_val) ? SAMPLE_IN : min_val;
   assign next_max = (SAMPLE_IN > max_val) ? SAMPLE_IN : max_val;

   always_comb begin
      auto_scale = scale;
      if ((span > HI_LIM) && (scale < SCALE_MAX)) begin
         auto_scale = scale + 3'd1;
      end else if ((span < LO_LIM) && (scale != 3'd0)) begin
         auto_scale = scale - 3'd1;
      end
   end

   // Simultaneous presses cancel; a press at either end of the range is a no-op
   always_comb begin
      manual_scale = scale;
      if (BTN_UP && !BTN_DOWN && (scale < SCALE_MAX)) begin
         manual_scale = scale + 3'd1;
      end else if (BTN_DOWN && !BTN_UP && (scale != 3'd0)) begin
         manual_scale = scale - 3'd1;
      end
   end

   assign auto_hit   = AUTO_EN && (auto_scale != scale);
   assign manual_hit = !AUTO_EN && (manual_scale != scale);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= ACQ;
         scale         <= SCALE_MAX;
         scale_changed <= 1'b0;
         span_reg      <= 12'd0;
         min_val       <= 12'hFFF;
         max_val       <= 12'd0;
         count         <= 17'd0;
         settle_cnt    <= 8'd0;
      end else begin
         scale_changed <= 1'b0;
         case (state)
            ACQ: begin
               if (manual_hit) begin
                  scale         <= manual_scale;
                  scale_changed <= 1'b1;
                  settle_cnt    <= SETTLE_LOAD;
                  state         <= SETTLE;
                  min_val       <= 12'hFFF;
                  max_val       <= 12'd0;
                  count         <= 17'd0;
               end else if (SAMPLE_VALID) begin
                  min_val <= next_min;
                  max_val <= next_max;
                  count   <= count + 17'd1;
                  if (count == WIN_LAST) begin
                     state <= DECIDE;
                  end
               end
            end
            DECIDE: begin
               span_reg <= span;
               min_val  <= 12'hFFF;
               max_val  <= 12'd0;
               count    <= 17'd0;
               if (auto_hit) begin
                  scale         <= auto_scale;
                  scale_changed <= 1'b1;
                  settle_cnt    <= SETTLE_LOAD;
                  state         <= SETTLE;
               end else begin
                  state <= ACQ;
               end
            end
            SETTLE: begin
               // The entry cycle counts as the first blanked cycle
               if (settle_cnt <= 8'd1) begin
                  settle_cnt <= 8'd0;
                  state      <= ACQ;
                  min_val    <= 12'hFFF;
                  max_val    <= 12'd0;
                  count      <= 17'd0;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            default: begin
               state      <= ACQ;
               settle_cnt <= 8'd0;
               min_val    <= 12'hFFF;
               max_val    <= 12'd0;
               count      <= 17'd0;
            end
         endcase
      end
   end

   assign SCALE         = scale;
   assign SCALE_CHANGED = scale_changed;
   assign BLANK         = (state == SETTLE);
   assign SPAN_OUT      = span_reg;
   assign STATE_OUT     = state;

endmodule
